// File: rtl/jt7759_romarb_if.sv
// rtl/jt7759_romarb_if.sv - bundle of both client ROM ports and the shared external ROM port
interface jt7759_romarb_if #(
  parameter int EAW = 22
);
  logic           c0_cs;
  logic [16:0]    c0_addr;
  logic           c0_flush;
  logic [7:0]     c0_data;
  logic           c0_ok;
  logic           c1_cs;
  logic [16:0]    c1_addr;
  logic           c1_flush;
  logic [7:0]     c1_data;
  logic           c1_ok;
  logic           ext_cs;
  logic [EAW-1:0] ext_addr;
  logic [7:0]     ext_data;
  logic           ext_ok;

  // master: the two voice controllers plus the ROM bridge; slave: the arbiter
  modport master (
    output c0_cs, c0_addr, c0_flush, input c0_data, c0_ok,
    output c1_cs, c1_addr, c1_flush, input c1_data, c1_ok,
    input  ext_cs, ext_addr, output ext_data, ext_ok
  );

  modport slave (
    input  c0_cs, c0_addr, c0_flush, output c0_data, c0_ok,
    input  c1_cs, c1_addr, c1_flush, output c1_data, c1_ok,
    output ext_cs, ext_addr, input ext_data, ext_ok
  );
endinterface

// File: rtl/jt7759_romarb.sv
// rtl/jt7759_romarb.sv - two-client ROM arbiter with one-byte latch per client
module jt7759_romarb #(
  parameter int             EAW     = 22,
  parameter logic [EAW-1:0] OFFSET0 = '0,
  parameter logic [EAW-1:0] OFFSET1 = EAW'('h20000)
) (
  input  logic                clk,
  input  logic                rstn,
  jt7759_romarb_if.slave      bus
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_FILL  = 4'b1000
  } state_t;

  state_t         st_q, st_d;
  logic           ext_cs_q, ext_cs_d;
  logic [EAW-1:0] ext_addr_q, ext_addr_d;
  logic [7:0]     data0_q, data0_d, data1_q, data1_d;
  logic [16:0]    tag0_q, tag0_d, tag1_q, tag1_d;
  logic           valid0_q, valid0_d, valid1_q, valid1_d;
  logic           last_q, last_d;
  logic           cur_id_q, cur_id_d;
  logic [16:0]    cur_addr_q, cur_addr_d;
  logic [7:0]     cap_q, cap_d;

  logic hit0, hit1, busy, pend0, pend1, gnt_id;

  always_comb begin
    hit0   = valid0_q && (tag0_q == bus.c0_addr);
    hit1   = valid1_q && (tag1_q == bus.c1_addr);
    busy   = (st_q != ST_IDLE);
    pend0  = bus.c0_cs && !hit0 && !(busy && !cur_id_q);
    pend1  = bus.c1_cs && !hit1 && !(busy && cur_id_q);
    // last_q=1 means client 1 was served most recently, so client 0 wins a tie
    gnt_id = pend1 && (!pend0 || !last_q);

    st_d       = st_q;
    ext_cs_d   = ext_cs_q;
    ext_addr_d = ext_addr_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    tag0_d     = tag0_q;
    tag1_d     = tag1_q;
    valid0_d   = valid0_q;
    valid1_d   = valid1_q;
    last_d     = last_q;
    cur_id_d   = cur_id_q;
    cur_addr_d = cur_addr_q;
    cap_d      = cap_q;

    case (st_q)
      ST_IDLE: begin
        if (pend0 || pend1) begin
          cur_id_d   = gnt_id;
          cur_addr_d = gnt_id ? bus.c1_addr : bus.c0_addr;
          ext_addr_d = gnt_id ? OFFSET1 + EAW'(bus.c1_addr) : OFFSET0 + EAW'(bus.c0_addr);
          ext_cs_d   = 1'b1;
          st_d       = ST_ISSUE;
        end
      end
      // ext_ok may still be high from the previous access; never sample it here
      ST_ISSUE: st_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.ext_ok) begin
          cap_d = bus.ext_data;
          st_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (cur_id_q) begin
          data1_d  = cap_q;
          tag1_d   = cur_addr_q;
          valid1_d = 1'b1;
        end else begin
          data0_d  = cap_q;
          tag0_d   = cur_addr_q;
          valid0_d = 1'b1;
        end
        last_d   = cur_id_q;
        ext_cs_d = 1'b0;
        st_d     = ST_IDLE;
      end
      default: begin
        ext_cs_d = 1'b0;
        st_d     = ST_IDLE;
      end
    endcase

    // flush overrides a fill landing in the same cycle
    if (bus.c0_flush) valid0_d = 1'b0;
    if (bus.c1_flush) valid1_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q       <= ST_IDLE;
      ext_cs_q   <= 1'b0;
      ext_addr_q <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      tag0_q     <= '0;
      tag1_q     <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      last_q     <= 1'b1;
      cur_id_q   <= 1'b0;
      cur_addr_q <= '0;
      cap_q      <= '0;
    end else begin
      st_q       <= st_d;
      ext_cs_q   <= ext_cs_d;
      ext_addr_q <= ext_addr_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      tag0_q     <= tag0_d;
      tag1_q     <= tag1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      last_q     <= last_d;
      cur_id_q   <= cur_id_d;
      cur_addr_q <= cur_addr_d;
      cap_q      <= cap_d;
    end
  end

  assign bus.c0_data  = data0_q;
  assign bus.c1_data  = data1_q;
  assign bus.c0_ok    = bus.c0_cs && hit0;
  assign bus.c1_ok    = bus.c1_cs && hit1;
  assign bus.ext_cs   = ext_cs_q;
  assign bus.ext_addr = ext_addr_q;

endmodule

// File: tb/tb_jt7759_romarb.sv
// tb/tb_jt7759_romarb.sv - directed self-checking bench for jt7759_romarb
module tb_jt7759_romarb;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  jt7759_romarb_if #(.EAW(22)) bus ();

  jt7759_romarb #(
    .EAW    (22),
    .OFFSET0(22'h000000),
    .OFFSET1(22'h020000)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ROM bridge model: answers mem_lat negedges after ext_cs rises; ok_stuck keeps
  // ext_ok high with garbage data whenever no real answer is being given
  int mem_lat  = 2;
  bit ok_stuck = 1'b0;
  int mem_cnt  = 0;

  function automatic logic [7:0] rom(input logic [21:0] a);
    return a[7:0] ^ 8'h5F ^ {2'b00, a[21:16]};
  endfunction

  always @(negedge clk) begin
    if (!bus.ext_cs) begin
      mem_cnt      = 0;
      bus.ext_ok   = ok_stuck;
      bus.ext_data = 8'hFF;
    end else begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        bus.ext_ok   = 1'b1;
        bus.ext_data = rom(bus.ext_addr);
      end else begin
        bus.ext_ok   = ok_stuck;
        bus.ext_data = 8'hFF;
      end
    end
  end

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.c0_ok;
      1:       return bus.c1_ok;
      2:       return bus.ext_cs;
      default: return bus.c0_ok && bus.c1_ok;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget && cyc < 0; i++) begin
      @(posedge clk);
      #1;
      if (sig(which)) cyc = i;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn         = 1'b0;
    bus.c0_cs    = 1'b0;
    bus.c1_cs    = 1'b0;
    bus.c0_flush = 1'b0;
    bus.c1_flush = 1'b0;
    bus.c0_addr  = '0;
    bus.c1_addr  = '0;
    ok_stuck     = 1'b0;
    mem_lat      = 2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.c0_cs = 1'b1;
    bus.c0_addr = 17'h0;
    bus.c1_cs = 1'b1;
    bus.c1_addr = 17'h0;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.ext_cs !== 1'b0) $display("FAIL reset_ext_cs: got %0b expected 0", bus.ext_cs); else n_pass++;
    n_total++;
    if (bus.ext_addr !== 22'h0) $display("FAIL reset_ext_addr: got %0h expected 0", bus.ext_addr); else n_pass++;
    n_total++;
    if (bus.c0_data !== 8'h0 || bus.c1_data !== 8'h0)
      $display("FAIL reset_data: got %0h/%0h expected 0/0", bus.c0_data, bus.c1_data);
    else n_pass++;
    n_total++;
    if (bus.c0_ok !== 1'b0 || bus.c1_ok !== 1'b0)
      $display("FAIL reset_ok: got %0b/%0b expected 0/0", bus.c0_ok, bus.c1_ok);
    else n_pass++;
    @(negedge clk);
    bus.c0_cs = 1'b0;
    bus.c1_cs = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_basic_read();
    int cyc;
    @(negedge clk);
    bus.c0_addr = 17'h00005;
    bus.c0_cs   = 1'b1;
    wait_sig(2, 10, cyc);
    n_total++;
    if (cyc !== 1) $display("FAIL t1_ext_cs_latency: got %0d expected 1", cyc); else n_pass++;
    n_total++;
    if (bus.ext_addr !== 22'h000005) $display("FAIL t1_ext_addr: got %0h expected 000005", bus.ext_addr); else n_pass++;
    wait_sig(0, 10, cyc);
    n_total++;
    if (cyc !== 3) $display("FAIL t1_ok_latency: got %0d expected 3", cyc); else n_pass++;
    n_total++;
    if (bus.c0_data !== 8'h5A) $display("FAIL t1_c0_data: got %0h expected 5a", bus.c0_data); else n_pass++;
    n_total++;
    if (bus.c1_ok !== 1'b0) $display("FAIL t1_c1_ok: got %0b expected 0", bus.c1_ok); else n_pass++;
    @(negedge clk);
    bus.c0_cs = 1'b0;
  endtask

  task automatic test_client1_step();
    int cyc;
    @(negedge clk);
    bus.c1_addr = 17'h00010;
    bus.c1_cs   = 1'b1;
    wait_sig(2, 10, cyc);
    n_total++;
    if (cyc < 0 || bus.ext_addr !== 22'h020010)
      $display("FAIL t2_ext_addr: got %0h (cyc %0d) expected 020010", bus.ext_addr, cyc);
    else n_pass++;
    wait_sig(1, 10, cyc);
    n_total++;
    if (cyc < 0 || bus.c1_data !== 8'h4D)
      $display("FAIL t2_c1_data: got %0h (cyc %0d) expected 4d", bus.c1_data, cyc);
    else n_pass++;
    @(negedge clk);
    bus.c1_addr = 17'h00011;
    #1;
    n_total++;
    if (bus.c1_ok !== 1'b0) $display("FAIL t2_ok_drop: got %0b expected 0", bus.c1_ok); else n_pass++;
    wait_sig(2, 5, cyc);
    n_total++;
    if (cyc !== 1 || bus.ext_addr !== 22'h020011)
      $display("FAIL t2_refetch: got addr %0h cyc %0d expected 020011 cyc 1", bus.ext_addr, cyc);
    else n_pass++;
    wait_sig(1, 10, cyc);
    n_total++;
    if (cyc < 0 || bus.c1_data !== 8'h4C)
      $display("FAIL t2_c1_data2: got %0h (cyc %0d) expected 4c", bus.c1_data, cyc);
    else n_pass++;
    @(negedge clk);
    bus.c1_cs = 1'b0;
  endtask

  task automatic test_fairness();
    int cyc;
    logic [21:0] ea0, ea1;
    for (int i = 0; i < 8; i++) begin
      ea0 = 22'h000100 + 22'(i);
      ea1 = 22'h020200 + 22'(i);
      @(negedge clk);
      bus.c0_addr = 17'h00100 + 17'(i);
      bus.c1_addr = 17'h00200 + 17'(i);
      bus.c0_cs = 1'b1;
      bus.c1_cs = 1'b1;
      wait_sig(2, 10, cyc);
      n_total++;
      if (cyc < 0 || bus.ext_addr !== ea0)
        $display("FAIL t3_first_grant[%0d]: got %0h expected %0h", i, bus.ext_addr, ea0);
      else n_pass++;
      wait_sig(0, 10, cyc);
      wait_sig(2, 10, cyc);
      n_total++;
      if (cyc < 0 || bus.ext_addr !== ea1)
        $display("FAIL t3_second_grant[%0d]: got %0h expected %0h", i, bus.ext_addr, ea1);
      else n_pass++;
      wait_sig(3, 10, cyc);
      n_total++;
      if (cyc < 0 || bus.c0_data !== rom(ea0) || bus.c1_data !== rom(ea1))
        $display("FAIL t3_data[%0d]: got %0h/%0h expected %0h/%0h", i, bus.c0_data, bus.c1_data, rom(ea0), rom(ea1));
      else n_pass++;
      @(negedge clk);
      bus.c0_cs = 1'b0;
      bus.c1_cs = 1'b0;
    end
    @(negedge clk);
    bus.c0_addr = 17'h00300;
    bus.c0_cs = 1'b1;
    wait_sig(0, 10, cyc);
    @(negedge clk);
    bus.c0_addr = 17'h00301;
    bus.c1_addr = 17'h00301;
    bus.c1_cs = 1'b1;
    wait_sig(2, 10, cyc);
    n_total++;
    if (cyc < 0 || bus.ext_addr !== 22'h020301)
      $display("FAIL t3_last0_grant: got %0h expected 020301", bus.ext_addr);
    else n_pass++;
    wait_sig(3, 20, cyc);
    n_total++;
    if (cyc < 0 || bus.c0_data !== 8'h5E || bus.c1_data !== 8'h5C)
      $display("FAIL t3_same_addr: got %0h/%0h expected 5e/5c", bus.c0_data, bus.c1_data);
    else n_pass++;
    @(negedge clk);
    bus.c0_cs = 1'b0;
    bus.c1_cs = 1'b0;
  endtask

  task automatic test_stuck_ok();
    int cyc;
    ok_stuck = 1'b1;
    mem_lat  = 2;
    @(negedge clk);
    bus.c0_addr = 17'h00044;
    bus.c0_cs = 1'b1;
    wait_sig(2, 10, cyc);
    n_total++;
    if (cyc !== 1) $display("FAIL t4_ext_cs_latency: got %0d expected 1", cyc); else n_pass++;
    wait_sig(0, 10, cyc);
    n_total++;
    if (cyc !== 3 || bus.c0_data !== 8'h1B)
      $display("FAIL t4_stuck_ok: got cyc %0d data %0h expected cyc 3 data 1b", cyc, bus.c0_data);
    else n_pass++;
    @(negedge clk);
    bus.c0_addr = 17'h00045;
    bus.c1_addr = 17'h00046;
    bus.c1_cs = 1'b1;
    wait_sig(3, 20, cyc);
    n_total++;
    if (cyc !== 8) $display("FAIL t4_back_to_back: got %0d cycles expected 8", cyc); else n_pass++;
    n_total++;
    if (bus.c0_data !== 8'h1A || bus.c1_data !== 8'h1B)
      $display("FAIL t4_b2b_data: got %0h/%0h expected 1a/1b", bus.c0_data, bus.c1_data);
    else n_pass++;
    @(negedge clk);
    bus.c0_cs = 1'b0;
    bus.c1_cs = 1'b0;
    ok_stuck = 1'b0;
  endtask

  task automatic test_hit_flush();
    int cyc;
    bit saw_cs;
    @(negedge clk);
    bus.c0_addr = 17'h00055;
    bus.c0_cs = 1'b1;
    wait_sig(0, 10, cyc);
    @(negedge clk);
    bus.c0_cs = 1'b0;
    #1;
    n_total++;
    if (bus.c0_ok !== 1'b0) $display("FAIL t5_ok_no_cs: got %0b expected 0", bus.c0_ok); else n_pass++;
    @(negedge clk);
    bus.c0_cs = 1'b1;
    #1;
    n_total++;
    if (bus.c0_ok !== 1'b1) $display("FAIL t5_hit_zero_latency: got %0b expected 1", bus.c0_ok); else n_pass++;
    saw_cs = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.ext_cs) saw_cs = 1'b1;
    end
    n_total++;
    if (saw_cs !== 1'b0) $display("FAIL t5_hit_no_ext: got %0b expected 0", saw_cs); else n_pass++;
    @(negedge clk);
    bus.c0_flush = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.c0_ok !== 1'b0) $display("FAIL t5_flush_drop: got %0b expected 0", bus.c0_ok); else n_pass++;
    @(negedge clk);
    bus.c0_flush = 1'b0;
    wait_sig(2, 5, cyc);
    n_total++;
    if (cyc !== 1 || bus.ext_addr !== 22'h000055)
      $display("FAIL t5_refetch: got addr %0h cyc %0d expected 000055 cyc 1", bus.ext_addr, cyc);
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_total++;
    if (bus.ext_cs !== 1'b1) $display("FAIL t5_fill_cycle: got ext_cs %0b expected 1", bus.ext_cs); else n_pass++;
    @(negedge clk);
    bus.c0_flush = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.c0_ok !== 1'b0) $display("FAIL t5_flush_vs_fill: got %0b expected 0", bus.c0_ok); else n_pass++;
    @(negedge clk);
    bus.c0_flush = 1'b0;
    wait_sig(0, 12, cyc);
    n_total++;
    if (cyc < 0 || bus.c0_data !== 8'h0A)
      $display("FAIL t5_refill: got %0h (cyc %0d) expected 0a", bus.c0_data, cyc);
    else n_pass++;
    @(negedge clk);
    bus.c0_cs = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit saw_ff;
    mem_lat = 20;
    @(negedge clk);
    bus.c1_addr = 17'h00046;
    bus.c1_cs = 1'b1;
    bus.c0_addr = 17'h00066;
    bus.c0_cs = 1'b1;
    #1;
    n_total++;
    if (bus.c1_ok !== 1'b1) $display("FAIL t6_c1_hit_before: got %0b expected 1", bus.c1_ok); else n_pass++;
    wait_sig(2, 10, cyc);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.ext_cs !== 1'b0) $display("FAIL t6_ext_cs_abort: got %0b expected 0", bus.ext_cs); else n_pass++;
    n_total++;
    if (bus.c0_ok !== 1'b0 || bus.c1_ok !== 1'b0)
      $display("FAIL t6_latches_invalid: got %0b/%0b expected 0/0", bus.c0_ok, bus.c1_ok);
    else n_pass++;
    @(negedge clk);
    ok_stuck = 1'b1;
    mem_lat = 2;
    bus.c1_cs = 1'b0;
    rstn = 1'b1;
    saw_ff = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 12 && cyc < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.c0_data === 8'hFF) saw_ff = 1'b1;
      if (bus.c0_ok) cyc = i;
    end
    n_total++;
    if (saw_ff !== 1'b0) $display("FAIL t6_stale_ff: got %0b expected 0", saw_ff); else n_pass++;
    n_total++;
    if (cyc < 0 || bus.c0_data !== 8'h39)
      $display("FAIL t6_after_reset: got %0h (cyc %0d) expected 39", bus.c0_data, cyc);
    else n_pass++;
    @(negedge clk);
    bus.c0_cs = 1'b0;
    ok_stuck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    test_reset();
    test_basic_read();
    test_client1_step();
    test_fairness();
    test_stuck_ok();
    test_hit_flush();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
